// File: rtl/tcp_session_responder.sv
// Passive-open TCP endpoint: SYN -> SYN-ACK, bidirectional byte payload, FIN answered with FIN.
// One-cycle latency rx->byte and byte->packet; single tx slot held until tcp_tx_ready, tx_ready_out low while occupied.
module tcp_session_responder #(
    parameter logic [31:0] ISN          = 32'h0000_2000,
    parameter int unsigned IDLE_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] local_port,
    input  logic        listen_en,
    input  logic        abort_req,
    output logic [3:0]  tcp_state,
    output logic        connection_established,
    output logic        connection_closed,
    output logic [15:0] peer_port,
    input  logic [7:0]  tx_data_in,
    input  logic        tx_valid_in,
    output logic        tx_ready_out,
    output logic [7:0]  rx_data_out,
    output logic        rx_valid_out,
    output logic [63:0] tcp_tx_packet,
    output logic        tcp_tx_valid,
    input  logic        tcp_tx_ready,
    input  logic [63:0] tcp_rx_packet,
    input  logic        tcp_rx_valid,
    output logic [31:0] bytes_sent,
    output logic [31:0] bytes_received,
    output logic [31:0] dropped_count
);

    typedef enum logic [3:0] {
        ST_CLOSED     = 4'd0,
        ST_SYN_RCVD   = 4'd2,
        ST_ESTAB      = 4'd3,
        ST_CLOSE_WAIT = 4'd8,
        ST_LAST_ACK   = 4'd9,
        ST_LISTEN     = 4'd10
    } state_t;

    localparam logic [31:0] FIN_PAYLOAD = 32'hFFFF_FFFF;
    localparam logic [31:0] IDLE_LIMIT  = 32'(IDLE_TIMEOUT);

    state_t      state_q, state_d;
    logic        est_q, est_d;
    logic        closed_q, closed_d;
    logic [15:0] peer_q, peer_d;
    logic [7:0]  rx_dat_q, rx_dat_d;
    logic        rx_vld_q, rx_vld_d;
    logic [63:0] tx_pkt_q, tx_pkt_d;
    logic        tx_vld_q, tx_vld_d;
    logic [31:0] sent_q, sent_d;
    logic [31:0] recv_q, recv_d;
    logic [31:0] drop_q, drop_d;
    logic [31:0] idle_q, idle_d;

    logic        rx_hit;
    logic        rx_ignored;
    logic        tx_xfer;
    logic        tx_accept;
    logic [15:0] rx_src;

    assign rx_src     = tcp_rx_packet[63:48];
    assign rx_hit     = tcp_rx_valid && (tcp_rx_packet[47:32] == local_port);
    assign rx_ignored = (state_q == ST_CLOSED) || (state_q == ST_SYN_RCVD) ||
                        (state_q == ST_CLOSE_WAIT) || (state_q == ST_LAST_ACK);
    assign tx_xfer    = tx_vld_q && tcp_tx_ready;
    assign tx_accept  = tx_valid_in && tx_ready_out;

    assign tx_ready_out = (state_q == ST_ESTAB) && !tx_vld_q && !abort_req;

    always_comb begin
        state_d  = state_q;
        peer_d   = peer_q;
        rx_dat_d = rx_dat_q;
        rx_vld_d = 1'b0;
        tx_pkt_d = tx_pkt_q;
        tx_vld_d = tx_vld_q;
        sent_d   = sent_q;
        recv_d   = recv_q;
        drop_d   = drop_q;
        idle_d   = 32'd0;

        if (tx_xfer) begin
            tx_vld_d = 1'b0;
        end

        if (abort_req) begin
            state_d  = ST_CLOSED;
            tx_vld_d = 1'b0;
        end else begin
            if (tcp_rx_valid && (!rx_hit || rx_ignored)) begin
                drop_d = drop_q + 32'd1;
            end

            case (state_q)
                ST_CLOSED: begin
                    if (listen_en) begin
                        state_d = ST_LISTEN;
                    end
                end
                ST_LISTEN: begin
                    if (rx_hit) begin
                        peer_d   = rx_src;
                        tx_pkt_d = {local_port, rx_src, ISN};
                        tx_vld_d = 1'b1;
                        state_d  = ST_SYN_RCVD;
                    end
                end
                ST_SYN_RCVD: begin
                    if (tx_xfer) begin
                        state_d = ST_ESTAB;
                    end
                end
                ST_ESTAB: begin
                    idle_d = idle_q + 32'd1;
                    if (tx_accept) begin
                        tx_pkt_d = {local_port, peer_q, tx_data_in, 24'h0};
                        tx_vld_d = 1'b1;
                        sent_d   = sent_q + 32'd1;
                    end
                    if (rx_hit) begin
                        if (tcp_rx_packet[31:0] == FIN_PAYLOAD) begin
                            state_d = ST_CLOSE_WAIT;
                        end else begin
                            rx_dat_d = tcp_rx_packet[31:24];
                            rx_vld_d = 1'b1;
                            recv_d   = recv_q + 32'd1;
                            idle_d   = 32'd0;
                        end
                    end else if (idle_d == IDLE_LIMIT) begin
                        state_d = ST_CLOSE_WAIT;
                    end
                end
                ST_CLOSE_WAIT: begin
                    // A byte still in the slot leaves first; the FIN takes the slot as it drains.
                    if (!tx_vld_q || tcp_tx_ready) begin
                        tx_pkt_d = {local_port, peer_q, FIN_PAYLOAD};
                        tx_vld_d = 1'b1;
                        state_d  = ST_LAST_ACK;
                    end
                end
                ST_LAST_ACK: begin
                    if (tx_xfer) begin
                        state_d = listen_en ? ST_LISTEN : ST_CLOSED;
                    end
                end
                default: begin
                    state_d  = ST_CLOSED;
                    tx_vld_d = 1'b0;
                end
            endcase
        end

        est_d    = (state_d == ST_ESTAB);
        closed_d = (state_d == ST_CLOSED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_CLOSED;
            est_q    <= 1'b0;
            closed_q <= 1'b1;
            peer_q   <= 16'd0;
            rx_dat_q <= 8'd0;
            rx_vld_q <= 1'b0;
            tx_pkt_q <= 64'd0;
            tx_vld_q <= 1'b0;
            sent_q   <= 32'd0;
            recv_q   <= 32'd0;
            drop_q   <= 32'd0;
            idle_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            est_q    <= est_d;
            closed_q <= closed_d;
            peer_q   <= peer_d;
            rx_dat_q <= rx_dat_d;
            rx_vld_q <= rx_vld_d;
            tx_pkt_q <= tx_pkt_d;
            tx_vld_q <= tx_vld_d;
            sent_q   <= sent_d;
            recv_q   <= recv_d;
            drop_q   <= drop_d;
            idle_q   <= idle_d;
        end
    end

    assign tcp_state              = state_q;
    assign connection_established = est_q;
    assign connection_closed      = closed_q;
    assign peer_port              = peer_q;
    assign rx_data_out            = rx_dat_q;
    assign rx_valid_out           = rx_vld_q;
    assign tcp_tx_packet          = tx_pkt_q;
    assign tcp_tx_valid           = tx_vld_q;
    assign bytes_sent             = sent_q;
    assign bytes_received         = recv_q;
    assign dropped_count          = drop_q;

endmodule

// File: tb/tb_tcp_session_responder.sv
// Scoreboard bench for tcp_session_responder: expected packets/bytes queued at stimulus, popped on DUT output.
module tb_tcp_session_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] local_port;
    logic        listen_en;
    logic        abort_req;
    logic [3:0]  tcp_state;
    logic        connection_established;
    logic        connection_closed;
    logic [15:0] peer_port;
    logic [7:0]  tx_data_in;
    logic        tx_valid_in;
    logic        tx_ready_out;
    logic [7:0]  rx_data_out;
    logic        rx_valid_out;
    logic [63:0] tcp_tx_packet;
    logic        tcp_tx_valid;
    logic        tcp_tx_ready;
    logic [63:0] tcp_rx_packet;
    logic        tcp_rx_valid;
    logic [31:0] bytes_sent;
    logic [31:0] bytes_received;
    logic [31:0] dropped_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp_tx[$];
    logic [7:0]  exp_rx[$];

    localparam logic [63:0] SYNACK_1234 = 64'h5000_1234_0000_2000;
    localparam logic [63:0] BYTE_7E     = 64'h5000_1234_7E00_0000;
    localparam logic [63:0] BYTE_42     = 64'h5000_1234_4200_0000;
    localparam logic [63:0] FIN_1234    = 64'h5000_1234_FFFF_FFFF;
    localparam logic [63:0] SYNACK_4321 = 64'h5000_4321_0000_2000;
    localparam logic [63:0] FIN_4321    = 64'h5000_4321_FFFF_FFFF;
    localparam logic [63:0] SYNACK_7777 = 64'h5000_7777_0000_2000;

    tcp_session_responder #(
        .ISN          (32'h0000_2000),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .local_port             (local_port),
        .listen_en              (listen_en),
        .abort_req              (abort_req),
        .tcp_state              (tcp_state),
        .connection_established (connection_established),
        .connection_closed      (connection_closed),
        .peer_port              (peer_port),
        .tx_data_in             (tx_data_in),
        .tx_valid_in            (tx_valid_in),
        .tx_ready_out           (tx_ready_out),
        .rx_data_out            (rx_data_out),
        .rx_valid_out           (rx_valid_out),
        .tcp_tx_packet          (tcp_tx_packet),
        .tcp_tx_valid           (tcp_tx_valid),
        .tcp_tx_ready           (tcp_tx_ready),
        .tcp_rx_packet          (tcp_rx_packet),
        .tcp_rx_valid           (tcp_rx_valid),
        .bytes_sent             (bytes_sent),
        .bytes_received         (bytes_received),
        .dropped_count          (dropped_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output-side scoreboard: every completed transfer / rx strobe must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (tcp_tx_valid && tcp_tx_ready) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", {63'd0, tcp_tx_valid}, 64'd0);
                else chk("tx_pkt", tcp_tx_packet, exp_tx.pop_front());
            end
            if (rx_valid_out) begin
                if (exp_rx.size() == 0) chk("rx_unexpected", {63'd0, rx_valid_out}, 64'd0);
                else chk("rx_byte", {56'd0, rx_data_out}, {56'd0, exp_rx.pop_front()});
            end
        end
    end

    initial begin
        int cnt;
        rst           = 1'b1;
        local_port    = 16'h5000;
        listen_en     = 1'b0;
        abort_req     = 1'b0;
        tx_data_in    = 8'h00;
        tx_valid_in   = 1'b0;
        tcp_tx_ready  = 1'b0;
        tcp_rx_packet = 64'd0;
        tcp_rx_valid  = 1'b0;
        repeat (3) tick();

        chk("rst_state", tcp_state, 0);
        chk("rst_closed", connection_closed, 1);
        chk("rst_est", connection_established, 0);
        chk("rst_peer", peer_port, 0);
        chk("rst_rxdat", rx_data_out, 0);
        chk("rst_txpkt", tcp_tx_packet, 0);
        chk("rst_txvld", tcp_tx_valid, 0);
        chk("rst_stats", {bytes_sent, bytes_received} | {32'd0, dropped_count}, 0);

        rst = 1'b0;
        listen_en = 1'b1;
        tick();
        chk("listen", tcp_state, 10);

        // SYN to the wrong port is dropped
        tcp_rx_packet = 64'h1234_6000_0000_1001;
        tcp_rx_valid  = 1'b1;
        tick();
        tcp_rx_valid = 1'b0;
        chk("drop1_state", tcp_state, 10);
        chk("drop1_cnt", dropped_count, 1);

        // Handshake with the SYN-ACK held, plus a packet dropped in SYN_RECEIVED
        tcp_rx_packet = 64'h1234_5000_0000_1001;
        tcp_rx_valid  = 1'b1;
        tick();
        chk("synrcvd_state", tcp_state, 2);
        chk("synack_pkt", tcp_tx_packet, SYNACK_1234);
        chk("synack_vld", tcp_tx_valid, 1);
        tcp_rx_packet = 64'h1234_5000_AA00_0000;
        tick();
        tcp_rx_valid = 1'b0;
        chk("drop2_state", tcp_state, 2);
        chk("drop2_cnt", dropped_count, 2);
        exp_tx.push_back(SYNACK_1234);
        tcp_tx_ready = 1'b1;
        tick();
        chk("est_state", tcp_state, 3);
        chk("est_flag", connection_established, 1);
        chk("est_closed", connection_closed, 0);
        chk("est_peer", peer_port, 16'h1234);
        chk("est_txvld", tcp_tx_valid, 0);

        // Receive two bytes back to back
        exp_rx.push_back(8'hA5);
        tcp_rx_packet = 64'h1234_5000_A500_0000;
        tcp_rx_valid  = 1'b1;
        tick();
        exp_rx.push_back(8'h3C);
        tcp_rx_packet = 64'h1234_5000_3C00_0000;
        chk("rx1_vld", rx_valid_out, 1);
        tick();
        tcp_rx_valid = 1'b0;
        chk("rx2_dat", rx_data_out, 8'h3C);
        chk("rx_count", bytes_received, 2);
        tick();
        chk("rx_strobe_end", rx_valid_out, 0);

        // Transmit under backpressure
        tcp_tx_ready = 1'b0;
        tx_data_in   = 8'h7E;
        tx_valid_in  = 1'b1;
        chk("txrdy_idle", tx_ready_out, 1);
        tick();
        tx_valid_in = 1'b0;
        exp_tx.push_back(BYTE_7E);
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", tcp_tx_valid, 1);
            chk("bp_pkt", tcp_tx_packet, BYTE_7E);
            chk("bp_txrdy", tx_ready_out, 0);
            tick();
        end
        tcp_tx_ready = 1'b1;
        tick();
        chk("sent1", bytes_sent, 1);
        chk("bp_drained", tcp_tx_valid, 0);

        // Byte accepted in the same cycle as the peer FIN goes out first
        tcp_tx_ready  = 1'b0;
        tx_data_in    = 8'h42;
        tx_valid_in   = 1'b1;
        tcp_rx_packet = 64'h1234_5000_FFFF_FFFF;
        tcp_rx_valid  = 1'b1;
        exp_tx.push_back(BYTE_42);
        exp_tx.push_back(FIN_1234);
        tick();
        tx_valid_in  = 1'b0;
        tcp_rx_valid = 1'b0;
        chk("cw_state", tcp_state, 8);
        chk("cw_pkt", tcp_tx_packet, BYTE_42);
        chk("sent2", bytes_sent, 2);
        tick();
        chk("cw_hold", tcp_state, 8);
        tcp_tx_ready = 1'b1;
        tick();
        chk("lastack_state", tcp_state, 9);
        chk("fin_pkt", tcp_tx_packet, FIN_1234);
        tick();
        chk("relisten", tcp_state, 10);
        chk("relisten_vld", tcp_tx_valid, 0);

        // Second session: idle timeout
        tcp_rx_packet = 64'h4321_5000_0000_0001;
        tcp_rx_valid  = 1'b1;
        exp_tx.push_back(SYNACK_4321);
        tick();
        tcp_rx_valid = 1'b0;
        tick();
        tcp_tx_ready = 1'b0;
        chk("est2_state", tcp_state, 3);
        cnt = 0;
        while (tcp_state != 4'd8 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("idle_cycles", cnt, 16);
        tick();
        chk("idle_fin_vld", tcp_tx_valid, 1);
        chk("idle_fin_pkt", tcp_tx_packet, FIN_4321);
        chk("idle_lastack", tcp_state, 9);

        // Abort while the FIN is pending
        listen_en = 1'b0;
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;
        chk("abort_state", tcp_state, 0);
        chk("abort_vld", tcp_tx_valid, 0);
        chk("abort_closed", connection_closed, 1);
        chk("abort_stats", {bytes_sent, bytes_received}, {32'd2, 32'd2});
        chk("abort_drops", dropped_count, 2);
        tick();
        chk("stay_closed", tcp_state, 0);

        // Third session: combinational tx_ready_out vs abort, then mid-session reset
        listen_en = 1'b1;
        tick();
        tcp_rx_packet = 64'h7777_5000_0000_0005;
        tcp_rx_valid  = 1'b1;
        tcp_tx_ready  = 1'b1;
        exp_tx.push_back(SYNACK_7777);
        tick();
        tcp_rx_valid = 1'b0;
        tick();
        chk("est3_state", tcp_state, 3);
        abort_req = 1'b1;
        #1;
        chk("txrdy_abort", tx_ready_out, 0);
        abort_req = 1'b0;
        #1;
        chk("txrdy_back", tx_ready_out, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_state", tcp_state, 0);
        chk("mrst_peer", peer_port, 0);
        chk("mrst_stats", {bytes_sent, bytes_received}, 0);
        chk("mrst_drops", dropped_count, 0);
        chk("mrst_vld", tcp_tx_valid, 0);

        tick();
        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("rx_queue_empty", exp_rx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
